// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM encoding and clog2 helper.
package rr_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, wrapping mod N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    int unsigned j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one register among N requesters with a per-tenure hold limit.
// Define RR_ARB_LOCK_EN to add the lock port, which lets the grantee extend its tenure.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [N-1:0]             req,
  input  logic [N-1:0]             wr_en,
  input  logic [N*WIDTH-1:0]       wdata,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]             lock,
`endif
  output logic [N-1:0]             gnt,
  output logic [clog2(N)-1:0]      gnt_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         q
);

  localparam int unsigned IDW = clog2(N);
  localparam int unsigned HW  = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HoldMax = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LastId  = IDW'(N - 1);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [IDW-1:0]   next_id;
  logic [IDW-1:0]   pick_ptr;
  logic [N-1:0]     pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             lock_hit;
  logic             cur_req;
  logic             release_now;

`ifdef RR_ARB_LOCK_EN
  assign lock_hit = |(gnt_q & lock);
`else
  assign lock_hit = 1'b0;
`endif

  assign next_id     = (id_q == LastId) ? '0 : id_q + 1'b1;
  assign cur_req     = |(gnt_q & req);
  assign release_now = !cur_req || ((hold_q == HoldMax) && !lock_hit);
  // On release the search restarts just past the outgoing grantee, so back-to-back hand-off
  // and the ptr update agree without waiting a cycle.
  assign pick_ptr    = (state_q == StGrant) ? next_id : ptr_q;

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    data_d  = data_q;

    // gnt_q is zero when idle, so only the grantee can write; a timeout-cycle write still lands.
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i] && req[i] && wr_en[i]) data_d = wdata[i*WIDTH +: WIDTH];
    end

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StGrant;
          gnt_d   = pick_onehot;
          id_d    = pick_idx;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (release_now) begin
          ptr_d  = next_id;
          hold_d = '0;
          if (pick_any) begin
            gnt_d = pick_onehot;
            id_d  = pick_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            id_d    = '0;
          end
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = |gnt_q;
  assign q      = data_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus randomized traffic vs. a model.
module tb_rr_reg_arbiter;

  localparam int N        = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic               clk;
  logic               nreset;
  logic [N-1:0]       req;
  logic [N-1:0]       wr_en;
  logic [N*WIDTH-1:0] wdata;
`ifdef RR_ARB_LOCK_EN
  logic [N-1:0]       lock;
`endif
  logic [N-1:0]       gnt;
  logic [1:0]         gnt_id;
  logic               busy;
  logic [WIDTH-1:0]   q;

  int checks;
  int errors;

  // Model: owner index (-1 idle), search start, cycles held in this tenure, register value.
  int               m_owner;
  int               m_ptr;
  int               m_ten;
  logic [WIDTH-1:0] m_q;

  rr_reg_arbiter #(
    .N       (N),
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .req   (req),
    .wr_en (wr_en),
    .wdata (wdata),
`ifdef RR_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_req(input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_ten   = 0;
    m_q     = '0;
  endtask

  task automatic model_edge();
    int  i;
    bit  locked;
    if (!nreset) begin
      model_reset();
    end else if (m_owner < 0) begin
      m_owner = find_req(m_ptr);
      m_ten   = 1;
    end else begin
      i      = m_owner;
      locked = 1'b0;
`ifdef RR_ARB_LOCK_EN
      locked = lock[i];
`endif
      if (req[i] && wr_en[i]) m_q = wdata[i*WIDTH +: WIDTH];
      if (!req[i] || (m_ten >= MAX_HOLD && !locked)) begin
        m_ptr   = (i + 1) % N;
        m_owner = find_req(m_ptr);
        m_ten   = 1;
      end else begin
        m_ten++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
    check("q", 32'(q), 32'(m_q));
  endtask

  // One clock: model follows the edge, then outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  // Asynchronous reset pulse away from the rising edge; outputs must clear immediately.
  task automatic pulse_reset();
    #2 nreset = 1'b0;
    #1;
    model_reset();
    compare_model();
    check("rst_gnt_now", 32'(gnt), 32'd0);
    check("rst_q_now", 32'(q), 32'd0);
    nreset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b1;
    req    = '0;
    wr_en  = '0;
    wdata  = '0;
`ifdef RR_ARB_LOCK_EN
    lock   = '0;
`endif
    model_reset();
    #1 nreset = 1'b0;

    // Reset held with every requester active and writing.
    req   = 4'hF;
    wr_en = 4'hF;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    compare_model();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_gnt", 32'(gnt), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_q", 32'(q), 32'd0);
    end

    // Single requester grant then write.
    nreset = 1'b1;
    req    = 4'b0100;
    wr_en  = 4'b0100;
    wdata  = 32'h00A5_0000;
    step();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_id", 32'(gnt_id), 32'd2);
    check("t2_q_before", 32'(q), 32'd0);
    step();
    check("t2_q", 32'(q), 32'hA5);
    req = '0;
    step();
    check("t2_idle", 32'(busy), 32'd0);

    // All requesting: rotation with MAX_HOLD cycles each, no dead cycle.
    pulse_reset();
    req   = 4'hF;
    wr_en = '0;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("t3_rot", 32'(gnt), 32'd1 << (((k - 1) / MAX_HOLD) % N));
    end

    // Non-grantee write ignored; release hands off in the same edge.
    pulse_reset();
    req   = 4'b0011;
    wr_en = 4'b0010;
    wdata = 32'h0000_3C00;
    step();
    check("t4_gnt0", 32'(gnt), 32'h1);
    step();
    check("t4_q_kept", 32'(q), 32'd0);
    req = 4'b0010;
    step();
    check("t4_gnt1", 32'(gnt), 32'h2);
    check("t4_id1", 32'(gnt_id), 32'd1);
    check("t4_q_still", 32'(q), 32'd0);
    step();
    check("t4_q_wr", 32'(q), 32'h3C);

    // Reset in the middle of requester 2's tenure.
    pulse_reset();
    req   = 4'b0100;
    wr_en = 4'b0100;
    wdata = 32'h005A_0000;
    step();
    step();
    check("t5_q_pre", 32'(q), 32'h5A);
    pulse_reset();
    req   = 4'b1001;
    wr_en = '0;
    step();
    check("t5_gnt", 32'(gnt), 32'h1);

    // Lock extension (or plain timeout without the lock feature).
    pulse_reset();
    req = 4'b0011;
`ifdef RR_ARB_LOCK_EN
    lock = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t6_locked", 32'(gnt), 32'h1);
    end
    lock = '0;
    step();
    check("t6_switch", 32'(gnt), 32'h2);
`else
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t6_hold", 32'(gnt), 32'h1);
    end
    step();
    check("t6_switch", 32'(gnt), 32'h2);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      req   = N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      wr_en = N'($urandom);
      wdata = $urandom;
`ifdef RR_ARB_LOCK_EN
      lock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
